// File: rtl/store_buffer_pkg.sv
// Shared dm access-type encodings and the byte-length helper used by the
// store buffer's overlap check.
package store_buffer_pkg;

    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    localparam int SB_LEN_W = 3;

    // Unknown encodings are treated as full words so the check stays conservative.
    function automatic logic [SB_LEN_W-1:0] sb_len(input logic [2:0] acc_type);
        case (acc_type)
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: sb_len = 3'd2;
            DM_BYTE, DM_BYTE_UNSIGNED:         sb_len = 3'd1;
            default:                           sb_len = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/sb_overlap.sv
// Pure combinational byte-range overlap test between one pending store and a load.
module sb_overlap
    import store_buffer_pkg::*;
#(
    parameter int AW = 9
) (
    input  logic [AW-1:0] i_st_addr,
    input  logic [2:0]    i_st_type,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [2:0]    i_ld_type,
    output logic          o_overlap
);

    logic [AW-1:0] w_d1;
    logic [AW-1:0] w_d2;

    // Modular distances make ranges that wrap past the top of dm compare correctly.
    assign w_d1 = i_ld_addr - i_st_addr;
    assign w_d2 = i_st_addr - i_ld_addr;

    assign o_overlap = (w_d1 < AW'(sb_len(i_st_type))) |
                       (w_d2 < AW'(sb_len(i_ld_type)));

endmodule

// File: rtl/store_buffer.sv
// In-order FIFO of committed stores between the MEM stage and dm, with a
// load-vs-pending-store hazard check across every valid entry.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 9
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [2:0]                 st_type,
    input  logic [31:0]                st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    input  logic [2:0]                 ld_type,
    output logic                       ld_hazard,
    input  logic                       dm_grant,
    output logic                       dm_we,
    output logic [AW-1:0]              dm_addr,
    output logic [2:0]                 dm_type,
    output logic [31:0]                dm_din,
    output logic                       sb_empty,
    output logic [$clog2(DEPTH):0]     sb_count
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] r_addr [DEPTH];
    logic [2:0]    r_type [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_overlap;

    assign w_empty  = (r_count == '0);
    assign st_ready = (r_count != (PW+1)'(DEPTH));
    assign w_push   = st_valid & st_ready;
    // Reset wins over a grant so nothing reaches dm in the reset cycle.
    assign dm_we    = dm_grant & ~w_empty & ~rst;
    assign w_pop    = dm_we;

    assign dm_addr  = w_empty ? '0 : r_addr[r_head];
    assign dm_type  = w_empty ? '0 : r_type[r_head];
    assign dm_din   = w_empty ? '0 : r_data[r_head];
    assign sb_empty = w_empty;
    assign sb_count = r_count;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off        = PW'(i) - r_head;
            w_valid[i] = ({1'b0, off} < r_count);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_ovl
        sb_overlap #(.AW(AW)) u_sb_overlap (
            .i_st_addr (r_addr[g]),
            .i_st_type (r_type[g]),
            .i_ld_addr (ld_addr),
            .i_ld_type (ld_type),
            .o_overlap (w_overlap[g])
        );
    end

    assign ld_hazard = ld_valid & |(w_valid & w_overlap);

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    // NOTE: entry storage is not reset; validity comes only from head/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= st_addr;
            r_type[r_tail] <= st_type;
            r_data[r_tail] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: reset, fill/drain, push+pop,
// overlap and wrap-around hazards, and reset in the middle of a drain.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [2:0]    st_type;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic [2:0]    ld_type;
    logic          ld_hazard;
    logic          dm_grant;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [2:0]    dm_type;
    logic [31:0]   dm_din;
    logic          sb_empty;
    logic [2:0]    sb_count;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .st_valid  (st_valid),
        .st_addr   (st_addr),
        .st_type   (st_type),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_type   (ld_type),
        .ld_hazard (ld_hazard),
        .dm_grant  (dm_grant),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_type   (dm_type),
        .dm_din    (dm_din),
        .sb_empty  (sb_empty),
        .sb_count  (sb_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_store(input logic v, input logic [AW-1:0] a, input logic [2:0] t,
                             input logic [31:0] d);
        st_valid = v;
        st_addr  = a;
        st_type  = t;
        st_data  = d;
    endtask

    task automatic set_load(input logic v, input logic [AW-1:0] a, input logic [2:0] t);
        ld_valid = v;
        ld_addr  = a;
        ld_type  = t;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        dm_grant = 1'b0;
        set_store(1'b0, '0, DM_WORD, '0);
        set_load(1'b0, '0, DM_WORD);

        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        set_load(1'b1, 9'h000, DM_WORD);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_empty",    32'(sb_empty), 32'd1);
        check("rst_count",    32'(sb_count), 32'd0);
        check("rst_dm_we",    32'(dm_we),    32'd0);
        check("rst_hazard",   32'(ld_hazard), 32'd0);
        set_load(1'b0, '0, DM_WORD);

        // Fill with dm_grant low
        for (int k = 0; k < 4; k++) begin
            set_store(1'b1, AW'(4 * k), DM_WORD, 32'h1111_1111 * (k + 1));
            tick();
        end
        set_store(1'b1, 9'h010, DM_WORD, 32'h5555_5555);
        #1;
        check("full_count", 32'(sb_count), 32'd4);
        check("full_ready", 32'(st_ready), 32'd0);
        check("full_no_we", 32'(dm_we),    32'd0);
        tick();
        check("fifth_rejected", 32'(sb_count), 32'd4);
        check("head_addr_held", 32'(dm_addr),  32'h000);
        set_store(1'b0, '0, DM_WORD, '0);

        // Drain in order
        dm_grant = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("drain_we",   32'(dm_we),   32'd1);
            check("drain_addr", 32'(dm_addr), 32'(4 * k));
            check("drain_din",  dm_din,       32'h1111_1111 * (k + 1));
            check("drain_type", 32'(dm_type), 32'(DM_WORD));
            tick();
        end
        check("drained_empty", 32'(sb_empty), 32'd1);
        check("drained_we",    32'(dm_we),    32'd0);
        check("drained_addr",  32'(dm_addr),  32'd0);

        // Simultaneous push/pop with two entries held
        dm_grant = 1'b0;
        set_store(1'b1, 9'h020, DM_WORD, 32'h0000_00A0);
        tick();
        set_store(1'b1, 9'h024, DM_WORD, 32'h0000_00B0);
        tick();
        dm_grant = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_store(1'b1, AW'(9'h028 + 4 * k), DM_WORD, 32'h0000_00C0 + 32'(16 * k));
            #1;
            check("pp_count", 32'(sb_count), 32'd2);
            check("pp_addr",  32'(dm_addr),  32'h020 + 32'(4 * k));
            check("pp_we",    32'(dm_we),    32'd1);
            tick();
        end
        set_store(1'b0, '0, DM_WORD, '0);
        check("pp_tail_addr0", 32'(dm_addr), 32'h034);
        check("pp_tail_din0",  dm_din,       32'h0000_00F0);
        tick();
        check("pp_tail_addr1", 32'(dm_addr), 32'h038);
        tick();
        check("pp_empty", 32'(sb_empty), 32'd1);

        // Byte store 0xAB@0x013 vs several loads
        dm_grant = 1'b0;
        set_store(1'b1, 9'h013, DM_BYTE, 32'h0000_00AB);
        tick();
        set_store(1'b0, '0, DM_WORD, '0);
        set_load(1'b1, 9'h010, DM_WORD);
        check("ovl_lw_010", 32'(ld_hazard), 32'd1);
        set_load(1'b1, 9'h012, DM_HALFWORD);
        check("ovl_lh_012", 32'(ld_hazard), 32'd1);
        set_load(1'b1, 9'h014, DM_HALFWORD);
        check("ovl_lh_014", 32'(ld_hazard), 32'd0);
        set_load(1'b1, 9'h012, DM_BYTE);
        check("ovl_lb_012", 32'(ld_hazard), 32'd0);
        set_load(1'b0, 9'h010, DM_WORD);
        check("ovl_no_valid", 32'(ld_hazard), 32'd0);
        dm_grant = 1'b1;
        set_load(1'b1, 9'h013, DM_BYTE_UNSIGNED);
        check("ovl_draining", 32'(ld_hazard), 32'd1);
        check("ovl_drain_we", 32'(dm_we),     32'd1);
        tick();
        set_load(1'b0, '0, DM_WORD);
        check("ovl_empty", 32'(sb_empty), 32'd1);

        // Word store at 0x1FF wraps to low addresses
        dm_grant = 1'b0;
        set_store(1'b1, 9'h1FF, DM_WORD, 32'hDEAD_BEEF);
        tick();
        set_store(1'b0, '0, DM_WORD, '0);
        set_load(1'b1, 9'h001, DM_BYTE);
        check("wrap_lb_001", 32'(ld_hazard), 32'd1);
        set_load(1'b1, 9'h003, DM_BYTE);
        check("wrap_lb_003", 32'(ld_hazard), 32'd0);
        set_load(1'b1, 9'h1FE, DM_BYTE);
        check("wrap_lb_1fe", 32'(ld_hazard), 32'd0);
        set_load(1'b0, '0, DM_WORD);
        dm_grant = 1'b1;
        tick();
        check("wrap_empty", 32'(sb_empty), 32'd1);

        // Reset with three entries pending and grant high
        dm_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_store(1'b1, AW'(9'h040 + 4 * k), DM_WORD, 32'h7000_0000 + 32'(k));
            tick();
        end
        set_store(1'b0, '0, DM_WORD, '0);
        check("pre_rst_count", 32'(sb_count), 32'd3);
        dm_grant = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_cycle_we", 32'(dm_we), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_empty", 32'(sb_empty), 32'd1);
        check("post_rst_count", 32'(sb_count), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("post_rst_no_we", 32'(dm_we), 32'd0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO of committed stores between the MEM stage and the data memory `dm`.
- MEM-stage stores retire into the buffer in one cycle. The buffer drains one store per granted cycle into dm's write port (DMWr/addr/DMType/din).
- Loads are checked against all pending stores. Any byte overlap raises a stall request, so a load never reads stale dm contents.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- AW, 9, byte-address width, matching dm addr[8:0].

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  MEM stage presents a store this cycle
- st_addr  in  AW  store byte address
- st_type  in  3  DMType of the store (dm_word/dm_halfword/dm_byte encodings)
- st_data  in  32  store data, right-justified as dm expects
- st_ready  out  1  buffer can accept a store (not full)
- ld_valid  in  1  MEM stage presents a load this cycle
- ld_addr  in  AW  load byte address
- ld_type  in  3  DMType of the load
- ld_hazard  out  1  load overlaps a pending store; pipeline must stall MEM and earlier stages
- dm_grant  in  1  dm write port is free this cycle (arbiter drives 0 while a load uses dm addr)
- dm_we  out  1  to dm DMWr
- dm_addr  out  AW  to dm addr
- dm_type  out  3  to dm DMType
- dm_din  out  32  to dm din
- sb_empty  out  1  no pending stores (used for fence/halt)
- sb_count  out  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Storage: DEPTH entries of {addr, type, data}, plus head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Reset (rst=1 at posedge): count=0 and both pointers=0; entry contents don't care.
  - Resulting outputs: st_ready=1, sb_empty=1, sb_count=0, dm_we=0, ld_hazard=0.
  - Reset mid-drain discards all pending stores; no dm write occurs in the reset cycle.
- Push: st_valid & st_ready at posedge writes the entry at tail and advances tail.
  - st_ready = (count != DEPTH), computed from registered count only. A pop in the same cycle does not allow a push when full.
  - st_valid while !st_ready: store is not taken. The pipeline must hold it (stall).
- Drain: dm_we = dm_grant & !sb_empty (combinational).
  - dm_addr/dm_type/dm_din always reflect the head entry. They are 0 when empty.
  - When dm_we is high, dm commits at that posedge and head advances.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty buffer: no bypass. The entry is first visible at dm the cycle after acceptance, so minimum store-to-dm latency is 1 cycle.
- Access length: len(type) = 4 for dm_word, 2 for dm_halfword/dm_halfword_unsigned, 1 for dm_byte/dm_byte_unsigned. Any other encoding uses len 4.
- Overlap rule, per valid entry e against the load:
  - d1 = (ld_addr − e.addr) mod 2^AW
  - d2 = (e.addr − ld_addr) mod 2^AW
  - overlap = (d1 < len(e.type)) | (d2 < len(ld_type))
  - Mod-2^AW arithmetic covers dm's word-index wrap (0x1FF word touches indices 127 and 0).
- ld_hazard = ld_valid & OR over valid entries of overlap. It is combinational and does not depend on dm_grant.
  - An entry draining in the current cycle still counts as a hazard that cycle.
- Non-overlapping loads: ld_hazard=0 even while the buffer is non-empty.
- Ordering: stores drain strictly in push order.
- dm_grant low for any number of cycles: contents held, no dm write.
- No internal $display; dm reports the writes.

Decomposition:
- Use the existing shared define file (ctrl_encode_def.v) for the dm_* type encodings. Add `sb_len` width constants there if needed. No new typedefs.
- One natural sub-module: sb_overlap. It is the pure combinational range check (addr/type pair vs addr/type pair → overlap), instantiated DEPTH times via generate.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → st_ready=1, sb_empty=1, sb_count=0, dm_we=0, ld_hazard=0.
- Fill and drain: dm_grant=0, push word stores 0x11111111@0x000, 0x22222222@0x004, 0x33333333@0x008, 0x44444444@0x00C.
  - → sb_count=4, st_ready=0; a 5th st_valid is not accepted.
  - Then dm_grant=1 → dm_we high 4 consecutive cycles, dm_addr 0x000, 0x004, 0x008, 0x00C in order, then sb_empty=1.
- Simultaneous push/pop: buffer holding 2 entries, dm_grant=1 and st_valid=1 every cycle for 5 cycles → sb_count stays 2, FIFO order preserved.
- Overlap detection, with pending byte store 0xAB@0x013:
  - lw@0x010 → ld_hazard=1
  - lh@0x012 → 1
  - lh@0x014 → 0
  - lb@0x012 → 0
- Wrap-around overlap: pending sw@0x1FF; lb@0x001 → ld_hazard=1; lb@0x003 → 0.
- Reset mid-operation: 3 entries pending, dm_grant=1, rst=1 one cycle → no dm_we that cycle, sb_empty=1 next cycle, no later writes of the old entries.
